// File: rtl/program_loader_if.sv
// Byte-stream receive handshake plus memory write port of the program loader.
// The loader drives the memory side through "master"; the byte source and memory use "slave".
interface program_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_write_enable, mem_address, mem_write_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> memory words, then checksum.
// The CPU is held in reset until the whole image has arrived with a matching checksum.
module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  program_loader_if.master      bus_io,
  output logic                  cpu_reset_o,
  output logic                  load_done_o,
  output logic                  load_error_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o
);
  localparam int BPW  = DATA_WIDTH / 8;
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(BPW - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_WIDTH;

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]            state_q,  state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q,    len_d;
  logic [DATA_WIDTH-1:0] word_q,   word_d;
  logic [IDXW-1:0]       idx_q,    idx_d;
  logic [ADDR_WIDTH:0]   words_q,  words_d;
  logic [7:0]            csum_q,   csum_d;
  logic                  we_q,     we_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic                  done_q,   done_d;
  logic                  err_q,    err_d;

  logic                  rx_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] assembled;
  logic [ADDR_WIDTH:0]   words_next;
  logic [15:0]           len_full;

  assign rx_ready = !reset_i && (state_q == S_LEN_LO || state_q == S_LEN_HI ||
                                 state_q == S_DATA   || state_q == S_CSUM);
  assign accept     = bus_io.rx_valid && rx_ready;
  assign words_next = words_q + 1'b1;
  assign len_full   = {bus_io.rx_data, len_lo_q};

  // New bytes enter at the top, so after BPW shifts the first byte sits in [7:0].
  generate
    if (BPW == 1) begin : g_single_byte
      assign assembled = bus_io.rx_data;
    end else begin : g_multi_byte
      assign assembled = {bus_io.rx_data, word_q[DATA_WIDTH-1:8]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    word_d   = word_q;
    idx_d    = idx_q;
    words_d  = words_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = bus_io.rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q + bus_io.rx_data;
          word_d = assembled;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            we_d    = 1'b1;
            wdata_d = assembled;
            addr_d  = words_q[ADDR_WIDTH-1:0];
            words_d = words_next;
            if (17'(words_next) == {1'b0, len_q}) begin
              state_d = S_CSUM;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus_io.rx_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Reset clears everything except memory, including any write strobe about to be issued.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_LEN_LO;
      len_lo_q <= '0;
      len_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      words_q  <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      words_q  <= words_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus_io.rx_ready         = rx_ready;
  assign bus_io.mem_write_enable = we_q;
  assign bus_io.mem_address      = addr_q;
  assign bus_io.mem_write_data   = wdata_q;
  assign cpu_reset_o             = ~done_q;
  assign load_done_o             = done_q;
  assign load_error_o            = err_q;
  assign words_loaded_o          = words_q;
endmodule
